// File: rtl/boruss_pkg.sv
// Shared BORUSS definitions: bus widths, FSM encodings and the HALT opcode
// used both as the instruction-memory fill value and by the CPU decoder.
package boruss_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int CNT_W     = 4;

    localparam logic [DATA_W-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } imem_state_e;

endpackage

// File: rtl/boruss_imem_responder_if.sv
// Fetch/load bus between the CPU side and the instruction-memory responder.
interface boruss_imem_responder_if;
    import boruss_pkg::*;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_ack;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              busy;
    logic [1:0]        state;

    modport master (
        output fetch_req, fetch_addr, load_en, load_addr, load_data,
        input  fetch_data, fetch_ack, busy, state
    );

    modport slave (
        input  fetch_req, fetch_addr, load_en, load_addr, load_data,
        output fetch_data, fetch_ack, busy, state
    );
endinterface

// File: rtl/boruss_imem_array.sv
// 256x8 instruction store: one synchronous write port, one combinational read
// port; every location returns to FILL_BYTE while reset is high.
module boruss_imem_array
    import boruss_pkg::*;
#(
    parameter logic [DATA_W-1:0] FILL_BYTE = HALT_OPCODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // Reset dominates, so a write strobe during reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= FILL_BYTE;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/boruss_imem_responder.sv
// Instruction-memory responder: latches a fetch, inserts WAIT_CYCLES wait
// states, then returns the byte with a one-cycle registered ack.
module boruss_imem_responder
    import boruss_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] FILL_BYTE   = HALT_OPCODE
) (
    input  logic                    clk,
    input  logic                    reset,
    boruss_imem_responder_if.slave  bus
);

    localparam int                WAIT_M1   = (WAIT_CYCLES > 0) ? int'(WAIT_CYCLES) - 1 : 0;
    localparam logic [CNT_W-1:0]  WAIT_INIT = WAIT_M1[CNT_W-1:0];

    imem_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              ack_q;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // With zero wait states the read happens on the sampling edge itself,
    // before addr_q has captured the request address.
    assign rd_addr = (state_q == ST_IDLE) ? bus.fetch_addr : addr_q;

    boruss_imem_array #(
        .FILL_BYTE (FILL_BYTE)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bus.load_en),
        .waddr_i (bus.load_addr),
        .wdata_i (bus.load_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (bus.fetch_req) begin
                        addr_q <= bus.fetch_addr;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_RESP;
                            data_q  <= rd_data;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RESP;
                        data_q  <= rd_data;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_data = data_q;
    assign bus.fetch_ack  = ack_q;
    assign bus.state      = state_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_boruss_imem_responder.sv
// Bench for boruss_imem_responder: three instances (WAIT_CYCLES 1, 0, 3)
// driven by directed and random fetch/load traffic against a memory model.
module tb_boruss_imem_responder;

    logic clk;
    logic reset;

    logic [2:0] req;
    logic [7:0] faddr [3];
    logic [2:0] ld_en;
    logic [7:0] laddr [3];
    logic [7:0] ldata [3];

    logic [2:0] ack_w;
    logic [2:0] busy_w;
    logic [7:0] data_w  [3];
    logic [1:0] state_w [3];

    int wcyc [3] = '{1, 0, 3};

    logic [7:0] model [3][256];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ack = 0;

    boruss_imem_responder_if bus0 ();
    boruss_imem_responder_if bus1 ();
    boruss_imem_responder_if bus2 ();

    assign bus0.fetch_req = req[0];
    assign bus0.fetch_addr = faddr[0];
    assign bus0.load_en = ld_en[0];
    assign bus0.load_addr = laddr[0];
    assign bus0.load_data = ldata[0];
    assign bus1.fetch_req = req[1];
    assign bus1.fetch_addr = faddr[1];
    assign bus1.load_en = ld_en[1];
    assign bus1.load_addr = laddr[1];
    assign bus1.load_data = ldata[1];
    assign bus2.fetch_req = req[2];
    assign bus2.fetch_addr = faddr[2];
    assign bus2.load_en = ld_en[2];
    assign bus2.load_addr = laddr[2];
    assign bus2.load_data = ldata[2];

    assign ack_w  = {bus2.fetch_ack, bus1.fetch_ack, bus0.fetch_ack};
    assign busy_w = {bus2.busy, bus1.busy, bus0.busy};
    assign data_w[0] = bus0.fetch_data;
    assign data_w[1] = bus1.fetch_data;
    assign data_w[2] = bus2.fetch_data;
    assign state_w[0] = bus0.state;
    assign state_w[1] = bus1.state;
    assign state_w[2] = bus2.state;

    boruss_imem_responder #(.WAIT_CYCLES(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    boruss_imem_responder #(.WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    boruss_imem_responder #(.WAIT_CYCLES(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 256; a++)
                model[k][a] = 8'hFF;
    endtask

    task automatic drive_ld(int k, logic [7:0] a, logic [7:0] d);
        ld_en[k] = 1'b1;
        laddr[k] = a;
        ldata[k] = d;
    endtask

    task automatic load(int k, logic [7:0] a, logic [7:0] d);
        drive_ld(k, a, d);
        tick();
        ld_en[k] = 1'b0;
        model[k][a] = d;
    endtask

    // wo: edge offset from the sampling edge at which a write happens (-1 none).
    // A write is visible to the fetch only if it lands strictly before edge E0+W.
    task automatic fetch(int k, logic [7:0] a, int wo, logic [7:0] wa, logic [7:0] wd);
        logic [7:0] exp_d;
        int n;
        int bn;
        exp_d = model[k][a];
        if (wo >= 0 && wo < wcyc[k] && wa == a) exp_d = wd;
        req[k] = 1'b1;
        faddr[k] = a;
        if (wo == 0) drive_ld(k, wa, wd);
        tick();
        req[k] = 1'b0;
        faddr[k] = ~a;
        ld_en[k] = 1'b0;
        if (wo == 1) drive_ld(k, wa, wd);
        n = 0;
        bn = 0;
        while (n < 20) begin
            if (busy_w[k]) bn++;
            if (ack_w[k]) break;
            tick();
            n++;
            ld_en[k] = 1'b0;
            if (wo == n + 1) drive_ld(k, wa, wd);
        end
        check("ack_seen", {31'd0, ack_w[k]}, 32'd1);
        check("latency", n, wcyc[k]);
        check("fetch_data", {24'd0, data_w[k]}, {24'd0, exp_d});
        check("busy_cycles", bn, wcyc[k] + 1);
        last_ack = cyc;
        tick();
        ld_en[k] = 1'b0;
        check("ack_one_cycle", {31'd0, ack_w[k]}, 32'd0);
        check("idle_after_resp", {31'd0, busy_w[k]}, 32'd0);
        if (wo >= 0) model[k][wa] = wd;
    endtask

    initial begin
        int t1;
        int n;
        int acks;
        req = '0;
        ld_en = '0;
        for (int k = 0; k < 3; k++) begin
            faddr[k] = '0;
            laddr[k] = '0;
            ldata[k] = '0;
        end
        model_reset();
        reset = 1'b1;
        #3;
        for (int k = 0; k < 3; k++) begin
            check("rst_state", {30'd0, state_w[k]}, 32'd0);
            check("rst_ack", {31'd0, ack_w[k]}, 32'd0);
            check("rst_data", {24'd0, data_w[k]}, 32'd0);
            check("rst_busy", {31'd0, busy_w[k]}, 32'd0);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Unloaded location reads the fill byte after W+1 edges
        fetch(0, 8'h10, -1, 8'h00, 8'h00);

        // Program load then back-to-back fetches, including the top address
        load(0, 8'h00, 8'h12);
        load(0, 8'h01, 8'h34);
        load(0, 8'hFF, 8'h8A);
        fetch(0, 8'h00, -1, 8'h00, 8'h00);
        t1 = last_ack;
        fetch(0, 8'h01, -1, 8'h00, 8'h00);
        check("spacing_0_1", last_ack - t1, 3);
        t1 = last_ack;
        fetch(0, 8'hFF, -1, 8'h00, 8'h00);
        check("spacing_1_ff", last_ack - t1, 3);

        // Zero and three wait states
        load(1, 8'h01, 8'h5C);
        fetch(1, 8'h01, -1, 8'h00, 8'h00);
        load(2, 8'h07, 8'hC3);
        fetch(2, 8'h07, -1, 8'h00, 8'h00);

        // Write on the RESP-entry edge: old byte, then new byte
        load(0, 8'h20, 8'h55);
        fetch(0, 8'h20, 1, 8'h20, 8'hAA);
        check("rbw_old", {24'd0, data_w[0]}, 32'h55);
        fetch(0, 8'h20, -1, 8'h00, 8'h00);
        check("rbw_new", {24'd0, data_w[0]}, 32'hAA);

        // Write during WAIT before the read edge is visible
        load(2, 8'h20, 8'h55);
        fetch(2, 8'h20, 1, 8'h20, 8'hAA);
        check("wait_write_seen", {24'd0, data_w[2]}, 32'hAA);

        // Held request is re-sampled in the IDLE after RESP
        req[0] = 1'b1;
        faddr[0] = 8'h01;
        n = 0;
        while (!ack_w[0] && n < 20) begin tick(); n++; end
        check("held_ack1", {31'd0, ack_w[0]}, 32'd1);
        t1 = cyc;
        tick();
        n = 0;
        while (!ack_w[0] && n < 20) begin tick(); n++; end
        check("held_ack2", {31'd0, ack_w[0]}, 32'd1);
        check("held_spacing", cyc - t1, wcyc[0] + 2);
        check("held_data", {24'd0, data_w[0]}, {24'd0, model[0][1]});
        req[0] = 1'b0;
        tick();
        tick();
        check("held_drain", {30'd0, state_w[0]}, 32'd0);

        // Reset mid-WAIT aborts; load during reset is dropped
        req[2] = 1'b1;
        faddr[2] = 8'h20;
        tick();
        req[2] = 1'b0;
        tick();
        check("pre_rst_wait", {30'd0, state_w[2]}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state", {30'd0, state_w[2]}, 32'd0);
        check("mid_rst_ack", {31'd0, ack_w[2]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_w[2]}, 32'd0);
        drive_ld(2, 8'h30, 8'h11);
        tick();
        ld_en[2] = 1'b0;
        reset = 1'b0;
        model_reset();
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack_w != 3'b000) acks++;
        end
        check("no_ack_after_rst", acks, 0);
        fetch(2, 8'h30, -1, 8'h00, 8'h00);
        fetch(2, 8'h20, -1, 8'h00, 8'h00);
        fetch(0, 8'h00, -1, 8'h00, 8'h00);

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            int k;
            int wo;
            logic [7:0] a;
            logic [7:0] wa;
            k = $urandom_range(0, 2);
            a = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = 8'hFF;
            if ($urandom_range(0, 1) == 1) load(k, a, 8'($urandom));
            if ($urandom_range(0, 2) == 0) load(k, 8'($urandom), 8'($urandom));
            wo = int'($urandom_range(0, wcyc[k] + 1)) - 1;
            wa = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
            fetch(k, a, wo, wa, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boruss_imem_responder.md
BORUSS_IMEM_RESPONDER -- requirements
Module: boruss_imem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SHALL set the number of wait states (0..15) inserted before each fetch response.
REQ-002 Parameter FILL_BYTE, default 8'hFF (HALT), SHALL be the value every memory location takes at reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fetch_req  input  1  instruction fetch request, sampled only in IDLE.
REQ-006 fetch_addr  input  8  fetch byte address, latched with the request.
REQ-007 fetch_data  output  8  instruction byte, registered, valid while fetch_ack=1.
REQ-008 fetch_ack  output  1  one-cycle registered response strobe.
REQ-009 load_en  input  1  program-load write strobe.
REQ-010 load_addr  input  8  program-load address.
REQ-011 load_data  input  8  program-load byte.
REQ-012 busy  output  1  high in WAIT or RESP.
REQ-013 state  output  2  current state encoding, for debug.

Function
REQ-014 The state machine SHALL have states IDLE=2'b00, WAIT=2'b01 and RESP=2'b10; code 2'b11 SHALL return to IDLE on the next edge.
REQ-015 In IDLE with fetch_req=1, the block SHALL latch fetch_addr. It SHALL then enter WAIT with the wait counter set to WAIT_CYCLES-1 (WAIT_CYCLES>0), or enter RESP directly (WAIT_CYCLES=0).
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the block SHALL enter RESP on the edge where the counter equals 0.
REQ-017 On the edge entering RESP, the block SHALL register fetch_data from memory at the latched address and set fetch_ack=1.
REQ-018 The block SHALL hold fetch_ack high for exactly one cycle (RESP), then return to IDLE.
REQ-019 Latency: if fetch_req is sampled at edge E0, fetch_ack SHALL be high during the cycle following edge E0+WAIT_CYCLES.
REQ-020 The minimum request spacing SHALL be WAIT_CYCLES+2 cycles. fetch_req SHALL be ignored in WAIT and RESP, and a request held high through RESP SHALL be re-sampled in the following IDLE cycle.
REQ-021 Deasserting fetch_req in WAIT SHALL NOT cancel the transaction; the block SHALL still complete it with an ack.
REQ-022 Writes: when load_en=1, the block SHALL write mem[load_addr] <= load_data on that edge, in any state, with no stall.
REQ-023 If a write and the RESP read hit the same address on the same edge, the read SHALL return the old byte (read-before-write).
REQ-024 A write to the latched address before the RESP read edge SHALL be visible in fetch_data.
REQ-025 Addresses 8'h00..8'hFF SHALL all be valid, with no wrap or error condition; address 8'hFF SHALL behave like any other.
REQ-026 fetch_data SHALL hold its last value outside RESP; consumers SHALL qualify it with fetch_ack.
REQ-027 busy SHALL equal (state!=IDLE) and SHALL be driven from registered state only.

Reset
REQ-028 While reset=1, asynchronously: state=IDLE, wait counter=0, fetch_ack=0, fetch_data=8'h00, latched address=8'h00, and all 256 locations SHALL equal FILL_BYTE.
REQ-029 Reset asserted mid-transaction (WAIT or RESP) SHALL abort it; no ack SHALL follow reset release unless a new request is sampled.
REQ-030 load_en asserted during reset SHALL be ignored.

Structure
REQ-031 Shared package boruss_pkg SHALL hold the state encodings, HALT_OPCODE=8'hFF (also used by the CPU FSM HALT decode) and the address/data width constants.
REQ-032 Storage SHALL be a single sub-module, boruss_imem_array (256x8, one synchronous write port, one read port), instantiated once.

Verification
REQ-033 Reset, WAIT_CYCLES=1, fetch addr 8'h10 with no load -> ack two cycles after the sampling edge, fetch_data=8'hFF.
REQ-034 Load 8'h00<=8'h12, 8'h01<=8'h34, 8'hFF<=8'h8A, then fetch 00, 01, FF back-to-back -> data 12, 34, 8A, each ack one cycle wide, requests spaced 3 cycles.
REQ-035 WAIT_CYCLES=0: fetch 8'h01 -> ack in the cycle after the sampling edge; WAIT_CYCLES=3 -> ack after edge E0+3, busy high for 4 cycles.
REQ-036 Fetch 8'h20 (holds 8'h55) and write 8'h20<=8'hAA on the RESP-entry edge -> data 8'h55; a following fetch -> 8'hAA.
REQ-037 Fetch 8'h20 and write 8'h20<=8'hAA during WAIT before the RESP-entry edge -> data 8'hAA.
REQ-038 Assert reset in WAIT -> fetch_ack stays 0, state=IDLE, memory reads 8'hFF. fetch_req held high through RESP -> the second ack arrives WAIT_CYCLES+2 cycles after the first.
